ni_admit_control_mc: RTL and testbench

NI_ADMIT_CONTROL_MC -- requirements
Module: ni_admit_control_mc

---
 rtl/ni_admit_control_mc.sv | 162 ++++++++++++++++
 tb/tb_ni_admit_control_mc.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ni_admit_control_mc.sv
// Network-interface admission control: per-virtual-channel header/payload flit counting,
// buffer-full flags, stall and sample strobes. Define NI_ADMIT_ERR_CHECK_EN for sticky framing errors.

module ni_admit_lane #(
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 v_valid,
  input  logic                 is_tail,
  input  logic                 clr_req,
  input  logic                 rcv_hdr,
  input  logic                 rcv_pay,
  input  logic                 is_read,
  input  logic [CNT_WIDTH-1:0] header_flits,
  input  logic [CNT_WIDTH-1:0] read_lim,
  input  logic [CNT_WIDTH-1:0] write_lim,
  output logic                 full_header,
  output logic                 full_payload,
  output logic [CNT_WIDTH-1:0] flit_count,
  output logic                 stall,
  output logic                 sample_header,
  output logic                 sample_payload,
  output logic                 packet_finished,
  output logic                 error
);
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, lim;
  logic fh_q, fh_d, fp_q, fp_d, pf_q, pf_d;
  logic hdr, pay, clear, hdr_last, pay_last;

  // Header phase wins when both phase inputs are raised.
  assign hdr      = rcv_hdr;
  assign pay      = rcv_pay & ~rcv_hdr;
  assign lim      = is_read ? read_lim : write_lim;
  assign hdr_last = (cnt_q == header_flits);
  assign pay_last = (cnt_q == lim);
  assign clear    = clr_req & (pf_q | fp_q);

  assign sample_header  = hdr & ~fh_q & v_valid;
  assign sample_payload = pay & ~fp_q & v_valid;
  assign stall          = hdr ? fh_q : (pay ? fp_q : 1'b1);

  always_comb begin
    cnt_d = cnt_q;
    fh_d  = fh_q;
    fp_d  = fp_q;
    pf_d  = pf_q;
    if (clear) begin
      cnt_d = '0;
      fh_d  = 1'b0;
      fp_d  = 1'b0;
    end else if (v_valid) begin
      // Any valid flit that does not advance the count returns it to zero (no wrap).
      if ((sample_payload && !pay_last) || (sample_header && !hdr_last))
        cnt_d = cnt_q + 1'b1;
      else
        cnt_d = '0;
      if (hdr && hdr_last) fh_d = 1'b1;
      if (pay && pay_last) fp_d = 1'b1;
      if (sample_header || sample_payload) pf_d = is_tail;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      fh_q  <= 1'b0;
      fp_q  <= 1'b0;
      pf_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      fh_q  <= fh_d;
      fp_q  <= fp_d;
      pf_q  <= pf_d;
    end
  end

  assign flit_count      = cnt_q;
  assign full_header     = fh_q;
  assign full_payload    = fp_q;
  assign packet_finished = pf_q;

`ifdef NI_ADMIT_ERR_CHECK_EN
  logic err_q, err_d;
  // Tail-ness must coincide exactly with the last payload slot: early tail or missing tail.
  assign err_d = err_q | (sample_payload & (is_tail ^ pay_last));
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign error = err_q;
`else
  assign error = 1'b0;
`endif
endmodule

module ni_admit_control_mc #(
  parameter int FLIT_WIDTH  = 32,
  parameter int NUM_VC      = 2,
  parameter int VC_SEL_W    = 1,
  parameter int CNT_WIDTH   = 4,
  parameter int FTYPE_WIDTH = 2,
  parameter logic [FTYPE_WIDTH-1:0] ENC_TAIL = 2'b10,
  parameter logic [FTYPE_WIDTH-1:0] ENC_SING = 2'b11
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           valid,
  input  logic [VC_SEL_W-1:0]            vc_sel,
  input  logic [FLIT_WIDTH-1:0]          flit,
  input  logic [NUM_VC-1:0]              clear_flit_count,
  input  logic [NUM_VC-1:0]              receiving_header,
  input  logic [NUM_VC-1:0]              receiving_payload,
  input  logic [NUM_VC-1:0]              packet_type_is_read,
  input  logic [CNT_WIDTH-1:0]           header_flits,
  input  logic [CNT_WIDTH-1:0]           read_payload_flits,
  input  logic [CNT_WIDTH-1:0]           write_payload_flits,
  output logic [NUM_VC-1:0]              full_header,
  output logic [NUM_VC-1:0]              full_payload,
  output logic [NUM_VC*CNT_WIDTH-1:0]    flit_count,
  output logic [NUM_VC-1:0]              stall,
  output logic [NUM_VC-1:0]              sample_header,
  output logic [NUM_VC-1:0]              sample_payload,
  output logic [NUM_VC-1:0]              packet_finished,
  output logic [NUM_VC-1:0]              error
);
  logic [FTYPE_WIDTH-1:0] ftype;
  logic is_tail;
  logic unused_flit_bits;

  assign ftype            = flit[FTYPE_WIDTH-1:0];
  assign is_tail          = (ftype == ENC_TAIL) || (ftype == ENC_SING);
  assign unused_flit_bits = ^flit[FLIT_WIDTH-1:FTYPE_WIDTH];

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    // Out-of-range vc_sel matches no lane.
    logic v_valid;
    assign v_valid = valid && (vc_sel == VC_SEL_W'(v));

    ni_admit_lane #(.CNT_WIDTH(CNT_WIDTH)) u_lane (
      .clk             (clk),
      .rst             (rst),
      .v_valid         (v_valid),
      .is_tail         (is_tail),
      .clr_req         (clear_flit_count[v]),
      .rcv_hdr         (receiving_header[v]),
      .rcv_pay         (receiving_payload[v]),
      .is_read         (packet_type_is_read[v]),
      .header_flits    (header_flits),
      .read_lim        (read_payload_flits),
      .write_lim       (write_payload_flits),
      .full_header     (full_header[v]),
      .full_payload    (full_payload[v]),
      .flit_count      (flit_count[v*CNT_WIDTH +: CNT_WIDTH]),
      .stall           (stall[v]),
      .sample_header   (sample_header[v]),
      .sample_payload  (sample_payload[v]),
      .packet_finished (packet_finished[v]),
      .error           (error[v])
    );
  end
endmodule

// File: tb/tb_ni_admit_control_mc.sv
// Directed table-driven bench for ni_admit_control_mc (NUM_VC=2, VC_SEL_W=2 so vc_sel=2/3 are out of range).
module tb_ni_admit_control_mc;
  localparam logic [1:0] B = 2'b00, T = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [1:0]  vc_sel;
  logic [31:0] flit;
  logic [1:0]  clear_flit_count, receiving_header, receiving_payload, packet_type_is_read;
  logic [3:0]  header_flits, read_payload_flits, write_payload_flits;
  logic [1:0]  full_header, full_payload, stall, sample_header, sample_payload, packet_finished, error;
  logic [7:0]  flit_count;

  int checks = 0;
  int failures = 0;

  ni_admit_control_mc #(.NUM_VC(2), .VC_SEL_W(2)) dut (
    .clk(clk), .rst(rst), .valid(valid), .vc_sel(vc_sel), .flit(flit),
    .clear_flit_count(clear_flit_count), .receiving_header(receiving_header),
    .receiving_payload(receiving_payload), .packet_type_is_read(packet_type_is_read),
    .header_flits(header_flits), .read_payload_flits(read_payload_flits),
    .write_payload_flits(write_payload_flits), .full_header(full_header),
    .full_payload(full_payload), .flit_count(flit_count), .stall(stall),
    .sample_header(sample_header), .sample_payload(sample_payload),
    .packet_finished(packet_finished), .error(error));

  always #5 clk = ~clk;

  typedef struct {
    logic vld; logic [1:0] vc; logic [1:0] ft;
    logic [1:0] clr, rh, rp, rd;
    logic [1:0] e_sh, e_sp, e_st;
    logic [3:0] e_c0, e_c1;
    logic [1:0] e_fh, e_fp, e_pf;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] vc, input logic [1:0] ft,
                       input logic [1:0] clr, input logic [1:0] rh, input logic [1:0] rp,
                       input logic [1:0] rd);
    valid = v; vc_sel = vc;
    flit = ($urandom() & 32'hFFFF_FFFC) | {30'h0, ft};
    clear_flit_count = clr; receiving_header = rh;
    receiving_payload = rp; packet_type_is_read = rd;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  int exp_err;

  initial begin
    tbl[0]  = '{1'b0, 2'd0, B, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00};
    tbl[1]  = '{1'b1, 2'd0, B, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 4'd1, 4'd0, 2'b00, 2'b00, 2'b00};
    tbl[2]  = '{1'b1, 2'd0, B, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 4'd0, 4'd0, 2'b01, 2'b00, 2'b00};
    tbl[3]  = '{1'b1, 2'd0, B, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 4'd0, 4'd0, 2'b01, 2'b00, 2'b00};
    tbl[4]  = '{1'b1, 2'd1, B, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b10, 2'b01, 4'd0, 4'd1, 2'b01, 2'b00, 2'b00};
    tbl[5]  = '{1'b1, 2'd1, B, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b10, 2'b01, 4'd0, 4'd2, 2'b01, 2'b00, 2'b00};
    tbl[6]  = '{1'b1, 2'd1, T, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b10, 2'b01, 4'd0, 4'd0, 2'b01, 2'b10, 2'b10};
    tbl[7]  = '{1'b0, 2'd1, B, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b11, 4'd0, 4'd0, 2'b01, 2'b00, 2'b10};
    tbl[8]  = '{1'b1, 2'd1, B, 2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 4'd0, 4'd1, 2'b01, 2'b00, 2'b00};
    tbl[9]  = '{1'b1, 2'd3, T, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 4'd0, 4'd1, 2'b01, 2'b00, 2'b00};
    tbl[10] = '{1'b1, 2'd2, T, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 4'd0, 4'd1, 2'b01, 2'b00, 2'b00};
    tbl[11] = '{1'b1, 2'd1, T, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 4'd0, 4'd0, 2'b11, 2'b00, 2'b10};

    header_flits = 4'd1; read_payload_flits = 4'd3; write_payload_flits = 4'd2;
    drive(1'b0, 2'd0, B, 2'b00, 2'b00, 2'b00, 2'b00);
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    chk("rst_count",  int'(flit_count), 0);
    chk("rst_fh",     int'(full_header), 0);
    chk("rst_fp",     int'(full_payload), 0);
    chk("rst_pf",     int'(packet_finished), 0);
    chk("rst_err",    int'(error), 0);
    chk("rst_stall",  int'(stall), 3);

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].vld, tbl[i].vc, tbl[i].ft, tbl[i].clr, tbl[i].rh, tbl[i].rp, tbl[i].rd);
      #1;
      chk($sformatf("v%0d_sh", i), int'(sample_header), int'(tbl[i].e_sh));
      chk($sformatf("v%0d_sp", i), int'(sample_payload), int'(tbl[i].e_sp));
      chk($sformatf("v%0d_stall", i), int'(stall), int'(tbl[i].e_st));
      tick;
      chk($sformatf("v%0d_c0", i), int'(flit_count[3:0]), int'(tbl[i].e_c0));
      chk($sformatf("v%0d_c1", i), int'(flit_count[7:4]), int'(tbl[i].e_c1));
      chk($sformatf("v%0d_fh", i), int'(full_header), int'(tbl[i].e_fh));
      chk($sformatf("v%0d_fp", i), int'(full_payload), int'(tbl[i].e_fp));
      chk($sformatf("v%0d_pf", i), int'(packet_finished), int'(tbl[i].e_pf));
      chk($sformatf("v%0d_err", i), int'(error), 0);
    end

    // Early tail on a read payload, then reset mid-packet.
`ifdef NI_ADMIT_ERR_CHECK_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    drive(1'b0, 2'd0, B, 2'b00, 2'b00, 2'b00, 2'b00);
    rst = 1'b1; tick; rst = 1'b0;
    drive(1'b1, 2'd0, B, 2'b00, 2'b00, 2'b01, 2'b01);
    tick;
    chk("et_c0_a", int'(flit_count[3:0]), 1);
    chk("et_err_a", int'(error), 0);
    drive(1'b1, 2'd0, T, 2'b00, 2'b00, 2'b01, 2'b01);
    tick;
    chk("et_c0_b", int'(flit_count[3:0]), 2);
    chk("et_pf_b", int'(packet_finished), 1);
    chk("et_err_b", int'(error), exp_err);
    drive(1'b0, 2'd0, B, 2'b00, 2'b00, 2'b01, 2'b01);
    tick;
    chk("et_err_hold", int'(error), exp_err);
    chk("et_c0_hold", int'(flit_count[3:0]), 2);
    drive(1'b1, 2'd0, B, 2'b00, 2'b00, 2'b01, 2'b01);
    rst = 1'b1; tick; rst = 1'b0;
    chk("mid_rst_count", int'(flit_count), 0);
    chk("mid_rst_pf", int'(packet_finished), 0);
    chk("mid_rst_fp", int'(full_payload), 0);
    chk("mid_rst_err", int'(error), 0);

    // Full-range limit on VC1: count climbs to 15 then returns to 0 with buffer full.
    write_payload_flits = 4'd15;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 2'd1, (i == 15) ? T : B, 2'b00, 2'b00, 2'b10, 2'b00);
      tick;
      chk($sformatf("wrap_c1_%0d", i), int'(flit_count[7:4]), (i == 15) ? 0 : i + 1);
    end
    chk("wrap_fp", int'(full_payload), 2);
    chk("wrap_pf", int'(packet_finished), 2);
    chk("wrap_c0", int'(flit_count[3:0]), 0);
    chk("wrap_err", int'(error), 0);
    drive(1'b0, 2'd0, B, 2'b00, 2'b00, 2'b10, 2'b00);
    #1;
    chk("wrap_stall", int'(stall), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
